// File: rtl/sram_bus_arbiter.sv
// Two-master SRAM-like bus arbiter (inst = master 0, data = master 1).
// Define ARB_RR_EN for round-robin; default is fixed data-over-inst priority.
module sram_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [AW-1:0] inst_addr,
  input  logic [DW-1:0] inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          s_req,
  output logic          s_wr,
  output logic [1:0]    s_size,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_addr_ok,
  input  logic          s_data_ok,
  input  logic [DW-1:0] s_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
`ifdef ARB_RR_EN
  logic   last_q, last_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifdef ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (inst_req | data_req) begin
          state_d = REQ;
`ifdef ARB_RR_EN
          // on a tie, the master not granted last time wins
          if (inst_req & data_req)
            grant_d = ~last_q;
          else
            grant_d = data_req;
          last_d = grant_d;
`else
          grant_d = data_req;
`endif
        end
      end
      REQ: begin
        if (s_addr_ok)
          state_d = s_data_ok ? IDLE : RESP;
      end
      RESP: begin
        if (s_data_ok)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
`ifdef ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  logic in_req;
  logic addr_hit;
  logic resp_hit;

  always_comb begin
    in_req   = (state_q == REQ);
    addr_hit = in_req & s_addr_ok;
    resp_hit = (addr_hit & s_data_ok)
             | ((state_q == RESP) & s_data_ok);

    s_req   = in_req;
    s_wr    = 1'b0;
    s_size  = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (in_req) begin
      s_wr    = grant_q ? data_wr    : inst_wr;
      s_size  = grant_q ? data_size  : inst_size;
      s_addr  = grant_q ? data_addr  : inst_addr;
      s_wdata = grant_q ? data_wdata : inst_wdata;
    end

    inst_addr_ok = addr_hit & ~grant_q;
    data_addr_ok = addr_hit &  grant_q;
    inst_data_ok = resp_hit & ~grant_q;
    data_data_ok = resp_hit &  grant_q;
    inst_rdata   = inst_data_ok ? s_rdata : '0;
    data_rdata   = data_data_ok ? s_rdata : '0;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter.
// Tie-order expectations follow ARB_RR_EN when it is defined.
module tb_sram_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req, inst_wr;
  logic [1:0]    inst_size;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_wdata;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          s_req, s_wr;
  logic [1:0]    s_size;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_addr_ok, s_data_ok;
  logic [DW-1:0] s_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .s_rdata(s_rdata)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".s_req"}, 64'(s_req), 0);
    check({tag, ".s_addr"}, 64'(s_addr), 0);
    check({tag, ".s_wr"}, 64'(s_wr), 0);
    check({tag, ".s_wdata"}, 64'(s_wdata), 0);
    check({tag, ".s_size"}, 64'(s_size), 0);
    check({tag, ".i_aok"}, 64'(inst_addr_ok), 0);
    check({tag, ".i_dok"}, 64'(inst_data_ok), 0);
    check({tag, ".i_rd"}, 64'(inst_rdata), 0);
    check({tag, ".d_aok"}, 64'(data_addr_ok), 0);
    check({tag, ".d_dok"}, 64'(data_data_ok), 0);
    check({tag, ".d_rd"}, 64'(data_rdata), 0);
  endtask

  logic [AW-1:0] first_a, second_a;

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 2;
    inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2;
    data_addr = 0; data_wdata = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
    settle;
    check_quiet("rst");
    tick; tick;
    resetn = 1'b1;

    // 1. inst only
    tick;
    inst_req = 1; inst_addr = 32'hbfc00000;
    settle;
    check("t1.idle_sreq", 64'(s_req), 0);
    tick;
    s_addr_ok = 1;
    settle;
    check("t1.s_req", 64'(s_req), 1);
    check("t1.s_addr", 64'(s_addr), 64'hbfc00000);
    check("t1.s_size", 64'(s_size), 2);
    check("t1.i_aok", 64'(inst_addr_ok), 1);
    check("t1.d_aok", 64'(data_addr_ok), 0);
    tick;
    inst_req = 0; s_addr_ok = 0;
    settle;
    check("t1.resp_sreq", 64'(s_req), 0);
    check("t1.resp_aok", 64'(inst_addr_ok), 0);
    tick;
    s_data_ok = 1; s_rdata = 32'h3c1d0000;
    settle;
    check("t1.i_dok", 64'(inst_data_ok), 1);
    check("t1.i_rd", 64'(inst_rdata), 64'h3c1d0000);
    check("t1.d_dok", 64'(data_data_ok), 0);
    check("t1.d_rd", 64'(data_rdata), 0);
    tick;
    s_data_ok = 0;
    settle;
    check_quiet("t1.done");

    // 2. simultaneous; data wins first arbitration
    inst_req = 1; inst_addr = 32'h100; inst_wr = 0;
    data_req = 1; data_addr = 32'h200; data_wr = 1;
    data_wdata = 32'hdeadbeef; data_size = 1;
    tick;
    s_addr_ok = 1;
    settle;
    check("t2.s_addr0", 64'(s_addr), 64'h200);
    check("t2.s_wr0", 64'(s_wr), 1);
    check("t2.s_wdata0", 64'(s_wdata), 64'hdeadbeef);
    check("t2.s_size0", 64'(s_size), 1);
    check("t2.d_aok", 64'(data_addr_ok), 1);
    check("t2.i_aok", 64'(inst_addr_ok), 0);
    tick;
    data_req = 0; s_addr_ok = 0; s_data_ok = 1;
    s_rdata = 32'h55aa55aa;
    settle;
    check("t2.d_dok", 64'(data_data_ok), 1);
    check("t2.i_dok", 64'(inst_data_ok), 0);
    check("t2.i_rd", 64'(inst_rdata), 0);
    tick;
    s_data_ok = 0;
    settle;
    check("t2.gap_sreq", 64'(s_req), 0);
    tick;
    // 4. addr_ok and data_ok together
    s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'h12345678;
    settle;
    check("t2.s_addr1", 64'(s_addr), 64'h100);
    check("t2.s_wr1", 64'(s_wr), 0);
    check("t4.i_aok", 64'(inst_addr_ok), 1);
    check("t4.i_dok", 64'(inst_data_ok), 1);
    check("t4.i_rd", 64'(inst_rdata), 64'h12345678);
    check("t4.d_dok", 64'(data_data_ok), 0);
    tick;
    inst_req = 0; s_addr_ok = 0; s_data_ok = 0;
    settle;
    check_quiet("t4.idle");

    // 3. data alone, then a tie
    data_req = 1; data_wr = 0; data_addr = 32'h300;
    tick;
    s_addr_ok = 1; s_data_ok = 1;
    settle;
    check("t3.pre_addr", 64'(s_addr), 64'h300);
    check("t3.pre_dok", 64'(data_data_ok), 1);
    tick;
    s_addr_ok = 0; s_data_ok = 0;
    inst_req = 1; data_req = 1; data_addr = 32'h200;
    first_a  = RR ? 32'h100 : 32'h200;
    second_a = RR ? 32'h200 : 32'h100;
    tick;
    s_addr_ok = 1; s_data_ok = 1;
    settle;
    check("t3.first", 64'(s_addr), 64'(first_a));
    tick;
    s_addr_ok = 0; s_data_ok = 0;
    if (RR) inst_req = 0; else data_req = 0;
    tick;
    s_addr_ok = 1; s_data_ok = 1;
    settle;
    check("t3.second", 64'(s_addr), 64'(second_a));
    tick;
    s_addr_ok = 0; s_data_ok = 0;
    inst_req = 0; data_req = 0;

    // 6. stall in REQ, stray data_ok ignored
    inst_req = 1; inst_addr = 32'h400;
    tick;
    for (int i = 0; i < 5; i++) begin
      s_data_ok = (i == 2);
      settle;
      check("t6.s_req", 64'(s_req), 1);
      check("t6.s_addr", 64'(s_addr), 64'h400);
      check("t6.i_aok", 64'(inst_addr_ok), 0);
      check("t6.i_dok", 64'(inst_data_ok), 0);
      tick;
    end
    s_data_ok = 0; s_addr_ok = 1;
    settle;
    check("t6.i_aok_end", 64'(inst_addr_ok), 1);
    tick;
    inst_req = 0; s_addr_ok = 0;

    // 5. reset in RESP
    s_data_ok = 1; s_rdata = 32'hcafef00d;
    resetn = 0;
    settle;
    check_quiet("t5.rst");
    tick;
    resetn = 1;
    inst_req = 1; inst_addr = 32'h500;
    s_addr_ok = 1;
    settle;
    check("t5.stale_dok", 64'(inst_data_ok), 0);
    check("t5.stale_aok", 64'(inst_addr_ok), 0);
    check("t5.stale_sreq", 64'(s_req), 0);
    tick;
    s_addr_ok = 0; s_data_ok = 0;
    settle;
    check("t5.s_req", 64'(s_req), 1);
    check("t5.s_addr", 64'(s_addr), 64'h500);
    s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'h0badf00d;
    settle;
    check("t5.i_dok", 64'(inst_data_ok), 1);
    check("t5.i_rd", 64'(inst_rdata), 64'h0badf00d);
    tick;
    inst_req = 0; s_addr_ok = 0; s_data_ok = 0;
    settle;
    check_quiet("t5.end");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
